// File: rtl/fifo_wptr_full_if.sv
// Write-side bundle of the async FIFO: producer request, synchronized read
// pointer in, and the RAM write port plus write-domain status out.
interface fifo_wptr_full_if #(
    parameter int ADDR_WIDTH = 4
);
    // Handshake: winc is the producer's request and wen is the acceptance. A
    // write happens on a clk edge only when wen is high (winc high and not
    // full); a request while full is dropped and recorded in wover.
    logic                  winc;
    logic [ADDR_WIDTH:0]   rptr_sync_gray;
    logic                  wen;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr_gray;
    logic                  wfull;
    logic                  walmost_full;
    logic                  wover;
    logic [ADDR_WIDTH:0]   wcount;

    modport master (
        output winc, rptr_sync_gray,
        input  wen, waddr, wptr_gray, wfull, walmost_full, wover, wcount
    );

    modport slave (
        input  winc, rptr_sync_gray,
        output wen, waddr, wptr_gray, wfull, walmost_full, wover, wcount
    );
endinterface

// File: rtl/fifo_wptr_full.sv
// Write-domain pointer, full / almost-full / overflow / fill-level logic for
// the asynchronous FIFO, working from the read pointer synchronized into clk.
module fifo_wptr_full #(
    parameter int ADDR_WIDTH   = 4,
    parameter int AFULL_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wptr_full_if.slave   bus
);
    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;

    // Inverting the top two Gray bits of the read pointer gives the Gray code
    // of a pointer exactly DEPTH ahead, i.e. the write pointer value at full.
    localparam logic [PW-1:0] FULL_MASK   = PW'(3) << (PW - 2);
    localparam logic [PW-1:0] AFULL_LEVEL = PW'(DEPTH - AFULL_THRESH);

    logic [PW-1:0] wbin;
    logic [PW-1:0] wgray_q;
    logic          wfull_q;
    logic          afull_q;
    logic          wover_q;
    logic [PW-1:0] wcount_q;

    logic          wen_c;
    logic [PW-1:0] wbin_next;
    logic [PW-1:0] wgray_next;
    logic [PW-1:0] rbin;
    logic [PW-1:0] count_next;
    logic          full_next;
    logic          afull_next;

    always_comb begin
        wen_c      = bus.winc & ~wfull_q;
        wbin_next  = wbin + PW'(wen_c);
        wgray_next = (wbin_next >> 1) ^ wbin_next;
    end

    // Gray to binary: bit i is the XOR of all Gray bits from i up to the MSB.
    always_comb begin
        rbin = '0;
        for (int i = 0; i < PW; i++) begin
            rbin[i] = ^(bus.rptr_sync_gray >> i);
        end
    end

    always_comb begin
        full_next  = (wgray_next == (bus.rptr_sync_gray ^ FULL_MASK));
        count_next = wbin_next - rbin;
        afull_next = (count_next >= AFULL_LEVEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wbin     <= '0;
            wgray_q  <= '0;
            wfull_q  <= 1'b0;
            afull_q  <= 1'b0;
            wover_q  <= 1'b0;
            wcount_q <= '0;
        end else begin
            wbin     <= wbin_next;
            wgray_q  <= wgray_next;
            wfull_q  <= full_next;
            afull_q  <= afull_next;
            wover_q  <= wover_q | (bus.winc & wfull_q);
            wcount_q <= count_next;
        end
    end

    assign bus.wen          = wen_c;
    assign bus.waddr        = wbin[ADDR_WIDTH-1:0];
    assign bus.wptr_gray    = wgray_q;
    assign bus.wfull        = wfull_q;
    assign bus.walmost_full = afull_q;
    assign bus.wover        = wover_q;
    assign bus.wcount       = wcount_q;
endmodule

// File: tb/tb_fifo_wptr_full.sv
// Self-checking bench for fifo_wptr_full (DEPTH=4, almost-full at 1 free slot)
// against an integer occupancy model of the write side.
module tb_fifo_wptr_full;
    logic clk;
    logic rst;

    fifo_wptr_full_if #(.ADDR_WIDTH(2)) bus ();

    fifo_wptr_full #(
        .ADDR_WIDTH   (2),
        .AFULL_THRESH (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: total accepted writes and registered status values.
    int   w_tot   = 0;
    int   m_count = 0;
    logic m_full  = 1'b0;
    logic m_afull = 1'b0;
    logic m_over  = 1'b0;
    logic m_valid = 1'b0;

    int r_true = 0;
    int lag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] gray(input int b);
        logic [2:0] x;
        x = b[2:0];
        return x ^ (x >> 1);
    endfunction

    // One clock cycle: drive inputs, check combinational outputs, advance the
    // model across the edge, then check registered outputs.
    task automatic step(input logic rst_v, input logic winc_v, input int r_bin);
        logic acc;
        rst                = rst_v;
        bus.winc           = winc_v;
        bus.rptr_sync_gray = gray(r_bin);
        #1;
        if (m_valid) begin
            check("wen", 32'(bus.wen), 32'(winc_v & ~m_full));
            check("waddr", 32'(bus.waddr), 32'(w_tot % 4));
        end
        @(posedge clk);
        #1;
        if (rst_v) begin
            w_tot   = 0;
            m_count = 0;
            m_full  = 1'b0;
            m_afull = 1'b0;
            m_over  = 1'b0;
            m_valid = 1'b1;
        end else begin
            acc     = winc_v & ~m_full;
            m_over  = m_over | (winc_v & m_full);
            w_tot   = w_tot + int'(acc);
            m_count = (w_tot - r_bin) & 7;
            m_full  = (m_count == 4);
            m_afull = (m_count >= 3);
        end
        check("wptr_gray", 32'(bus.wptr_gray), 32'(gray(w_tot)));
        check("wfull", 32'(bus.wfull), 32'(m_full));
        check("walmost_full", 32'(bus.walmost_full), 32'(m_afull));
        check("wover", 32'(bus.wover), 32'(m_over));
        check("wcount", 32'(bus.wcount), 32'(m_count));
    endtask

    logic [2:0] fill_gray [4];
    int r_now;

    initial begin
        fill_gray = '{3'b001, 3'b011, 3'b010, 3'b110};
        rst = 1'b1;
        bus.winc = 1'b0;
        bus.rptr_sync_gray = '0;

        // Reset held two cycles with a pending write request.
        step(1'b1, 1'b1, 0);
        step(1'b1, 1'b1, 0);
        check("rst_wcount", 32'(bus.wcount), 32'd0);

        // Fill from empty, fifth request overflows.
        for (int i = 0; i < 5; i++) begin
            if (i < 4) check("fill_waddr", 32'(bus.waddr), 32'(i));
            step(1'b0, 1'b1, 0);
            if (i < 4) check("fill_gray", 32'(bus.wptr_gray), 32'(fill_gray[i]));
            if (i == 2) check("fill_afull3", 32'(bus.walmost_full), 32'd1);
            if (i == 3) check("fill_full4", 32'(bus.wfull), 32'd1);
        end
        check("fill_over", 32'(bus.wover), 32'd1);

        // Release one slot, then write into it.
        step(1'b0, 1'b0, 1);
        check("rel_count", 32'(bus.wcount), 32'd3);
        step(1'b0, 1'b1, 1);
        check("rel_full_again", 32'(bus.wfull), 32'd1);

        // Wrap: reader trails the writer by two cycles.
        step(1'b1, 1'b0, 0);
        lag_q = '{0, 0};
        for (int i = 0; i < 9; i++) begin
            r_now = lag_q.pop_front();
            step(1'b0, 1'b1, r_now);
            lag_q.push_back(w_tot);
            if (i == 7) check("wrap_gray0", 32'(bus.wptr_gray), 32'd0);
            check("wrap_nofull", 32'(bus.wfull), 32'd0);
        end

        // Write and read together at count DEPTH-1.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 0);
        step(1'b0, 1'b1, 1);
        check("simul_count", 32'(bus.wcount), 32'd3);
        check("simul_nofull", 32'(bus.wfull), 32'd0);

        // Reset mid-operation with wover set and wcount=2.
        step(1'b1, 1'b0, 0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 0);
        step(1'b0, 1'b0, 2);
        check("mid_count2", 32'(bus.wcount), 32'd2);
        step(1'b1, 1'b1, 2);
        check("mid_rst_over", 32'(bus.wover), 32'd0);

        // Randomized traffic with a lagging, never-overtaking reader.
        step(1'b1, 1'b0, 0);
        r_true = 0;
        lag_q  = '{0, 0};
        for (int i = 0; i < 600; i++) begin
            r_now = lag_q.pop_front();
            if ($urandom_range(0, 99) == 0) begin
                step(1'b1, 1'($urandom_range(0, 1)), r_now);
                r_true = 0;
                lag_q  = '{0};
            end else begin
                step(1'b0, ($urandom_range(0, 9) < 6), r_now);
                if ($urandom_range(0, 1) == 1 && r_true < w_tot) r_true++;
            end
            lag_q.push_back(r_true);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/fifo_wptr_full.md
# fifo_wptr_full

Write-domain pointer and full-flag generator for the asynchronous FIFO. It consumes the read pointer after it has crossed into the write clock domain through the synchronizer chain. From that it produces the RAM write address, the write enable, and a Gray-coded write pointer that is handed to the synchronizer chain going to the read domain. It also generates full, almost-full, overflow and fill-level status, all seen from the write side.

## Interface
- ADDR_WIDTH, 4, RAM address width; DEPTH = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- AFULL_THRESH, 2, free slots at or below which walmost_full asserts; legal range 1..DEPTH-1.

- clk  in  1  write-domain clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- winc  in  1  write request from the producer.
- rptr_sync_gray  in  ADDR_WIDTH+1  read pointer (Gray code), already synchronized into clk.
- wen  out  1  RAM write enable; combinational, equals winc & ~wfull.
- waddr  out  ADDR_WIDTH  RAM write address; equals wbin[ADDR_WIDTH-1:0].
- wptr_gray  out  ADDR_WIDTH+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered almost-full flag.
- wover  out  1  sticky overflow flag: set when winc arrives while wfull is high.
- wcount  out  ADDR_WIDTH+1  registered fill level, 0..DEPTH.

## Operation
- State registers: wbin and wptr_gray (both ADDR_WIDTH+1 bits), wfull, walmost_full, wover, wcount.
- Next-state values, computed each cycle:
  - wbin_next = wbin + wen, modulo 2**(ADDR_WIDTH+1).
  - wgray_next = (wbin_next >> 1) ^ wbin_next.
- Full detection: full_next = (wgray_next == {~rptr_sync_gray[MSB:MSB-1], rptr_sync_gray[MSB-2:0]}).
- Fill level:
  - rbin = Gray-to-binary of rptr_sync_gray (combinational XOR prefix).
  - count_next = wbin_next - rbin, modulo 2**(ADDR_WIDTH+1).
- Almost-full: afull_next = (count_next >= DEPTH - AFULL_THRESH).
- Overflow: wover <= wover | (winc & wfull). It is cleared only by rst.
- Behaviour when full: winc is ignored; wbin, waddr and wptr_gray hold; no RAM write occurs.
- Wrap-around: after 2*DEPTH writes, wbin returns to 0. The pointer MSB distinguishes full from empty.
- Pessimism: rptr_sync_gray lags the true read pointer. As a result, wfull and wcount may overstate fullness, but never understate it. No overflow of the RAM is possible.
- Simultaneous write and read advance at count DEPTH-1: wen=1, count stays DEPTH-1, wfull stays 0.
- Reset: applies on the next clk edge regardless of winc. The write is not counted, and all registered outputs go to 0.

## Timing
- Reset values: wbin=0, wptr_gray=0, waddr=0, wfull=0, walmost_full=0, wover=0, wcount=0. wen=0 while wfull=0 and winc=0.
- wen and waddr are valid in the same cycle as winc. The RAM captures the data at the same edge that advances wbin.
- wptr_gray, wfull, walmost_full and wcount reflect an accepted write 1 cycle after it.
- A change on rptr_sync_gray affects wfull, walmost_full and wcount at the next clk edge, i.e. 1 cycle later.
- wptr_gray is a registered output and changes at most 1 bit per cycle, which makes it safe to synchronize.

## Test plan
All scenarios use ADDR_WIDTH=2 (DEPTH=4) and AFULL_THRESH=1.
- Reset: rst=1 for 2 cycles with winc=1 → all outputs 0, no pointer advance; after rst=0 the first write uses waddr=0.
- Fill with rptr_sync_gray=000 and winc=1 for 5 cycles:
  - waddr = 0,1,2,3.
  - wptr_gray = 001, 011, 010, 110.
  - walmost_full rises after the 3rd write (wcount=3).
  - wfull rises after the 4th write.
  - 5th cycle: wen=0, wptr_gray holds 110, wover=1 on the next edge.
- Release: while full, drive rptr_sync_gray 000→001 → one cycle later wfull=0, wcount=3, walmost_full=1; the next winc gives wen=1, waddr=0.
- Wrap: rptr_sync_gray follows wptr_gray with a 2-cycle delay while 9 writes are issued → waddr wraps 3→0 twice, wptr_gray returns to 000 after the 8th write, and wfull never asserts.
- Simultaneous events: at wcount=3, winc=1 in the same cycle rptr_sync_gray advances by one → wen=1, wcount stays 3, wfull stays 0.
- Reset mid-operation: wcount=2 and wover=1, then rst=1 with winc=1 → next edge: wbin=0, wptr_gray=0, wcount=0, wover=0, wfull=0.
